// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Port indices select bits of the two-bit request/grant vectors.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        LOCK = 2'd1,
        COOL = 2'd2
    } arb_state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on contention the port that did not win last time wins.
// A lone requester is always granted; no request gives no grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU load/store path and the DMA engine.
// Round-robin with an optional bounded DMA lock; read data is steered back by a registered owner tag.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_rvalid,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_stall,

    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [WIDTH-1:0] dma_addr,
    input  logic [WIDTH-1:0] dma_wdata,
    output logic             dma_gnt,
    output logic             dma_rvalid,
    output logic [WIDTH-1:0] dma_rdata,
    input  logic             dma_lock,

    output logic [WIDTH-1:0] mem_A,
    output logic             mem_WE,
    output logic [WIDTH-1:0] mem_WD,
    input  logic [WIDTH-1:0] mem_RD,

    output arb_state_t       dbg_state
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX  = CW'(MAX_LOCK);
    localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

    arb_state_t    state;
    logic          last_gnt;
    logic [CW-1:0] lock_cnt;
    logic          cpu_tag;
    logic          dma_tag;
    logic [1:0]    rr_gnt;
    logic [1:0]    gnt;

    rr_arb2 u_rr (
        .req  ({dma_req, cpu_req}),
        .last (last_gnt),
        .gnt  (rr_gnt)
    );

    // Grants are combinational so an uncontended access completes in the request cycle.
    always_comb begin
        gnt = 2'b00;
        case (state)
            ARB:     gnt = rr_gnt;
            LOCK:    gnt[PORT_DMA] = dma_req;
            COOL: begin
                gnt[PORT_CPU] = cpu_req;
                gnt[PORT_DMA] = dma_req & ~cpu_req;
            end
            default: gnt = 2'b00;
        endcase
        if (rst) begin
            gnt = 2'b00;
        end
    end

    assign cpu_gnt   = gnt[PORT_CPU];
    assign dma_gnt   = gnt[PORT_DMA];
    assign cpu_stall = cpu_req & ~cpu_gnt & ~rst;

    always_comb begin
        mem_A  = '0;
        mem_WE = 1'b0;
        mem_WD = '0;
        if (gnt[PORT_CPU]) begin
            mem_A  = cpu_addr;
            mem_WE = cpu_we;
            mem_WD = cpu_wdata;
        end else if (gnt[PORT_DMA]) begin
            mem_A  = dma_addr;
            mem_WE = dma_we;
            mem_WD = dma_wdata;
        end
    end

    assign cpu_rvalid = cpu_tag;
    assign dma_rvalid = dma_tag;
    assign cpu_rdata  = cpu_tag ? mem_RD : '0;
    assign dma_rdata  = dma_tag ? mem_RD : '0;
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB;
            last_gnt <= 1'b1;
            lock_cnt <= '0;
            cpu_tag  <= 1'b0;
            dma_tag  <= 1'b0;
        end else begin
            cpu_tag <= cpu_gnt & ~cpu_we;
            dma_tag <= dma_gnt & ~dma_we;
            if (|gnt) begin
                last_gnt <= gnt[PORT_DMA];
            end
            case (state)
                ARB: begin
                    // The entry grant itself is the first locked cycle.
                    if (dma_gnt && dma_lock) begin
                        lock_cnt <= CW'(1);
                        state    <= (MAX_LOCK == 1) ? COOL : LOCK;
                    end
                end
                LOCK: begin
                    // A lock drop wins over reaching the limit in the same cycle.
                    if (!dma_lock) begin
                        state    <= ARB;
                        last_gnt <= 1'b1;
                        lock_cnt <= '0;
                    end else begin
                        if (lock_cnt < LOCK_MAX) begin
                            lock_cnt <= lock_cnt + CW'(1);
                        end
                        if (lock_cnt >= LOCK_LAST) begin
                            state <= COOL;
                        end
                    end
                end
                COOL: begin
                    if (!dma_lock) begin
                        state    <= ARB;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ARB;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a behavioural arbitration model.
// Expected grants and read data are queued at issue time and popped by an independent monitor.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int W        = 32;
    localparam int MAX_LOCK = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
    logic [W-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic         dma_req, dma_we, dma_gnt, dma_rvalid, dma_lock;
    logic [W-1:0] dma_addr, dma_wdata, dma_rdata;
    logic [W-1:0] mem_A, mem_WD, mem_RD;
    logic         mem_WE;
    arb_state_t   dbg_state;

    dmem_arbiter #(.WIDTH(W), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_lock(dma_lock),
        .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / data memory ----------------
    always #5 clk = ~clk;

    logic [W-1:0] mem [0:255];
    logic [W-1:0] ref_mem [0:255];
    logic [W-1:0] mem_rd_q;

    always @(posedge clk) begin
        mem_rd_q <= mem[mem_A[9:2]];
        if (mem_WE) mem[mem_A[9:2]] = mem_WD;
    end
    assign mem_RD = mem_rd_q;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
    } txn_t;

    typedef struct packed {
        logic         cg;
        logic         dg;
        logic         stall;
        logic [W-1:0] a;
        logic         we;
        logic [W-1:0] wd;
    } exp_t;

    txn_t         cpu_txq[$];
    txn_t         dma_txq[$];
    exp_t         exp_gnt_q[$];
    logic [W-1:0] exp_cpu_q[$];
    logic [W-1:0] exp_dma_q[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: who won last, length of the current locked run, cool-down flag.
    int m_last;
    int m_run;
    bit m_cool;

    function automatic txn_t mk(input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = W'($urandom_range(0, 255)) << 2;
        t.wdata = $urandom;
        return t;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 1; m_run = 0; m_cool = 1'b0;
        cpu_txq.delete(); dma_txq.delete();
        exp_gnt_q.delete(); exp_cpu_q.delete(); exp_dma_q.delete();
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1: present queue heads, predict the winner, advance the model one cycle.
    task automatic step();
        txn_t c, d;
        exp_t e;
        int   win;
        c = (cpu_txq.size() > 0) ? cpu_txq[0] : rand_txn();
        d = (dma_txq.size() > 0) ? dma_txq[0] : rand_txn();
        cpu_req = (cpu_txq.size() > 0);
        dma_req = (dma_txq.size() > 0);
        cpu_we = c.we; cpu_addr = c.addr; cpu_wdata = c.wdata;
        dma_we = d.we; dma_addr = d.addr; dma_wdata = d.wdata;

        win = -1;
        if (m_cool)                  win = cpu_req ? 0 : (dma_req ? 1 : -1);
        else if (m_run > 0)          win = dma_req ? 1 : -1;
        else if (cpu_req && dma_req) win = (m_last == 0) ? 1 : 0;
        else if (cpu_req)            win = 0;
        else if (dma_req)            win = 1;

        e = '0;
        e.stall = cpu_req && (win != 0);
        if (win == 0) begin
            e.cg = 1'b1; e.a = c.addr; e.we = c.we; e.wd = c.wdata;
            if (c.we) ref_mem[c.addr[9:2]] = c.wdata;
            else exp_cpu_q.push_back(ref_mem[c.addr[9:2]]);
            void'(cpu_txq.pop_front());
        end else if (win == 1) begin
            e.dg = 1'b1; e.a = d.addr; e.we = d.we; e.wd = d.wdata;
            if (d.we) ref_mem[d.addr[9:2]] = d.wdata;
            else exp_dma_q.push_back(ref_mem[d.addr[9:2]]);
            void'(dma_txq.pop_front());
        end
        exp_gnt_q.push_back(e);

        if (m_cool) begin
            if (!dma_lock) begin m_cool = 1'b0; m_run = 0; end
        end else if (m_run > 0) begin
            if (!dma_lock) m_run = 0;
            else begin
                m_run++;
                if (m_run >= MAX_LOCK) m_cool = 1'b1;
            end
        end else if (win == 1 && dma_lock) begin
            m_run = 1;
            if (m_run >= MAX_LOCK) m_cool = 1'b1;
        end
        if (win >= 0) m_last = win;

        @(posedge clk); #1;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((cpu_txq.size() > 0 || dma_txq.size() > 0) && n < max_cycles) begin
            step();
            n++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    bit   prev_cr = 1'b0;
    bit   prev_dr = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_cr = 1'b0; prev_dr = 1'b0;
        end else if (mon_en) begin
            if (exp_gnt_q.size() == 0) begin
                chk("grant_queue_empty", 1, 0);
            end else begin
                mon_e = exp_gnt_q.pop_front();
                chk("cpu_gnt",   W'(cpu_gnt),   W'(mon_e.cg));
                chk("dma_gnt",   W'(dma_gnt),   W'(mon_e.dg));
                chk("cpu_stall", W'(cpu_stall), W'(mon_e.stall));
                chk("mem_A",     mem_A,         mon_e.a);
                chk("mem_WE",    W'(mem_WE),    W'(mon_e.we));
                chk("mem_WD",    mem_WD,        mon_e.wd);
            end
            chk("cpu_rvalid", W'(cpu_rvalid), W'(prev_cr));
            chk("dma_rvalid", W'(dma_rvalid), W'(prev_dr));
            if (prev_cr && exp_cpu_q.size() > 0) chk("cpu_rdata", cpu_rdata, exp_cpu_q.pop_front());
            else                                 chk("cpu_rdata_idle", cpu_rdata, '0);
            if (prev_dr && exp_dma_q.size() > 0) chk("dma_rdata", dma_rdata, exp_dma_q.pop_front());
            else                                 chk("dma_rdata_idle", dma_rdata, '0);
            prev_cr = mon_e.cg & ~mon_e.we;
            prev_dr = mon_e.dg & ~mon_e.we;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cpu_gnt"},    W'(cpu_gnt),    '0);
        chk({tag, "_dma_gnt"},    W'(dma_gnt),    '0);
        chk({tag, "_cpu_stall"},  W'(cpu_stall),  '0);
        chk({tag, "_cpu_rvalid"}, W'(cpu_rvalid), '0);
        chk({tag, "_dma_rvalid"}, W'(dma_rvalid), '0);
        chk({tag, "_cpu_rdata"},  cpu_rdata,      '0);
        chk({tag, "_dma_rdata"},  dma_rdata,      '0);
        chk({tag, "_mem_A"},      mem_A,          '0);
        chk({tag, "_mem_WE"},     W'(mem_WE),     '0);
        chk({tag, "_mem_WD"},     mem_WD,         '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = W'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
            ref_mem[i] = W'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
        end
        mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;

        rst = 1'b1; dma_lock = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = '0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'h1234;
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Lone CPU read of the preloaded word.
        cpu_txq.push_back(mk(1'b0, 32'h10, 32'h0));
        drain(20); idle(2);

        // Continuous contention: CPU reads vs DMA writes.
        for (int i = 0; i < 6; i++) begin
            cpu_txq.push_back(mk(1'b0, W'(32'h20 + 4 * i), 32'h0));
            dma_txq.push_back(mk(1'b1, W'(32'h100 + 4 * i), W'(32'h100 + i)));
        end
        drain(40); idle(2);

        // Short lock (5 cycles), below the limit.
        for (int i = 0; i < 8; i++) dma_txq.push_back(mk(1'b1, W'(32'h200 + 4 * i), W'(32'hB000 + i)));
        for (int i = 0; i < 4; i++) cpu_txq.push_back(mk(1'b0, W'(32'h200 + 4 * i), 32'h0));
        dma_lock = 1'b1;
        for (int i = 0; i < 5; i++) step();
        dma_lock = 1'b0;
        drain(40); idle(2);

        // Long lock (10 cycles): forced release, then CPU priority in cool-down.
        for (int i = 0; i < 14; i++) dma_txq.push_back(mk(1'b1, W'(32'h300 + 4 * i), W'(32'hC000 + i)));
        for (int i = 0; i < 6; i++) cpu_txq.push_back(mk(1'b0, W'(32'h300 + 4 * i), 32'h0));
        dma_lock = 1'b1;
        for (int i = 0; i < 10; i++) step();
        dma_lock = 1'b0;
        drain(60); idle(2);

        // Asynchronous reset landing on a CPU read grant.
        mon_en = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4; cpu_wdata = '0;
        dma_req = 1'b0; dma_lock = 1'b0;
        #1 chk("pre_rst_cpu_gnt", W'(cpu_gnt), W'(1));
        rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(posedge clk); #1 chk_all_zero("rst_held");
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
        mon_en = 1'b1;

        // Back-to-back reads right after reset: CPU wins the first contention.
        cpu_txq.push_back(mk(1'b0, 32'h4, 32'h0));
        dma_txq.push_back(mk(1'b0, 32'h8, 32'h0));
        drain(10); idle(3);

        // Random traffic with a randomly toggling lock.
        for (int i = 0; i < 400; i++) begin
            if (cpu_txq.size() == 0 && $urandom_range(0, 99) < 60) cpu_txq.push_back(rand_txn());
            if (dma_txq.size() == 0 && $urandom_range(0, 99) < 60) dma_txq.push_back(rand_txn());
            if ($urandom_range(0, 99) < 12) dma_lock = ~dma_lock;
            step();
        end
        dma_lock = 1'b0;
        drain(60); idle(3);
        mon_en = 1'b0;

        chk("leftover_cpu_rdata", W'(exp_cpu_q.size()), '0);
        chk("leftover_dma_rdata", W'(exp_dma_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
